balance_cntrl_p: RTL and testbench

BALANCE_CNTRL_P -- requirements
Module: balance_cntrl_p

---
 rtl/balance_cntrl_p.sv | 200 ++++++++++++++++++++
 tb/tb_balance_cntrl_p.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/balance_cntrl_p.sv
`timescale 1ns/1ps
// Self-balancing platform controller: soft-start FSM, saturating PID on pitch,
// soft-start scaling and steering mix, in a three-stage pipeline.
module balance_cntrl_p #(
    parameter int FAST_SIM     = 0,
    parameter int SPD_W        = 12,
    parameter int TOO_FAST_LIM = 1536
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld,
    input  logic [15:0]      ptch,
    input  logic [15:0]      ptch_rt,
    input  logic             pwr_up,
    input  logic             rider_off,
    input  logic [11:0]      steer_pot,
    input  logic             en_steer,
    output logic [SPD_W-1:0] lft_spd,
    output logic [SPD_W-1:0] rght_spd,
    output logic             too_fast,
    output logic             out_vld,
    output logic             ss_done
);
    localparam int PRESC_W = (FAST_SIM != 0) ? 7 : 15;
    localparam logic signed [16:0] SPD_MAX = 17'((32'sd1 <<< (SPD_W - 1)) - 32'sd1);
    localparam logic signed [16:0] SPD_MIN = 17'(-(32'sd1 <<< (SPD_W - 1)));
    localparam logic signed [16:0] LIM     = 17'(TOO_FAST_LIM);

    typedef enum logic [1:0] {OFF = 2'd0, RAMP = 2'd1, RUN = 2'd2} state_t;

    function automatic logic signed [9:0] sat10(input logic signed [15:0] v);
        if (v > 16'sd511)       return 10'sd511;
        else if (v < -16'sd512) return -10'sd512;
        else                    return v[9:0];
    endfunction

    function automatic logic signed [11:0] sat12(input logic signed [17:0] v);
        if (v > 18'sd2047)       return 12'sd2047;
        else if (v < -18'sd2048) return -12'sd2048;
        else                     return v[11:0];
    endfunction

    function automatic logic signed [17:0] sat18(input logic signed [18:0] v);
        if (v > 19'sd131071)       return 18'sd131071;
        else if (v < -19'sd131072) return -18'sd131072;
        else                       return v[17:0];
    endfunction

    function automatic logic signed [SPD_W-1:0] sat_spd(input logic signed [16:0] v);
        if (v > SPD_MAX)      return SPD_MAX[SPD_W-1:0];
        else if (v < SPD_MIN) return SPD_MIN[SPD_W-1:0];
        else                  return v[SPD_W-1:0];
    endfunction

    function automatic logic signed [16:0] abs17(input logic signed [SPD_W-1:0] v);
        logic signed [16:0] w;
        w = 17'(v);
        return (w < 17'sd0) ? -w : w;
    endfunction

    state_t                     state_r, state_nxt_s;
    logic [PRESC_W-1:0]         presc_r;
    logic [7:0]                 ss_tmr_r;
    logic                       ss_done_r;
    logic signed [17:0]         integ_r;
    logic                       v_s1_r, v_s2_r, out_vld_r, too_fast_r;
    logic signed [9:0]          err_s1_r, rt_s1_r;
    logic signed [11:0]         i_s1_r, pid_s2_r;
    logic signed [SPD_W-1:0]    lft_spd_r, rght_spd_r;

    logic                       acc_s, tmr_wrap_s, too_fast_s, unused_s;
    logic signed [9:0]          err_s;
    logic signed [18:0]         integ_sum_s;
    logic signed [13:0]         p_s;
    logic signed [17:0]         sum_s;
    logic signed [11:0]         pid_s;
    logic signed [20:0]         prod_s;
    logic signed [12:0]         pid_ss_s, steer_s;
    logic [11:0]                pot_clip_s;
    logic signed [14:0]         st3_s;
    logic signed [10:0]         st_s;
    logic signed [16:0]         lft_sum_s, rght_sum_s;
    logic signed [SPD_W-1:0]    lft_sat_s, rght_sat_s;

    assign acc_s      = vld && pwr_up && (state_r != OFF);
    assign tmr_wrap_s = (state_r == RAMP) && !rider_off && (presc_r == {PRESC_W{1'b1}});

    // Stage 1 datapath: input saturation and integrator accumulation.
    assign err_s       = sat10($signed(ptch));
    assign integ_sum_s = 19'(integ_r) + 19'(err_s);

    // Stage 2 datapath: P + I + D with D = -(ptch_rt >>> 6).
    assign p_s   = 14'(err_s1_r) * 14'sd5;
    assign sum_s = 18'(p_s) + 18'(i_s1_r) - 18'(rt_s1_r);
    assign pid_s = sat12(sum_s);

    // Stage 3 datapath: soft-start scaling, steering mix and output saturation.
    assign prod_s     = 21'(pid_s2_r) * 21'($signed({1'b0, ss_tmr_r}));
    assign pid_ss_s   = prod_s[20:8];
    assign pot_clip_s = (steer_pot < 12'h200) ? 12'h200 :
                        ((steer_pot > 12'hE00) ? 12'hE00 : steer_pot);
    assign steer_s    = $signed({1'b0, pot_clip_s}) - 13'sd2047;
    assign st3_s      = 15'(steer_s) * 15'sd3;
    assign st_s       = en_steer ? st3_s[14:4] : 11'sd0;
    assign lft_sum_s  = 17'(pid_ss_s) + 17'(st_s);
    assign rght_sum_s = 17'(pid_ss_s) - 17'(st_s);
    assign lft_sat_s  = sat_spd(lft_sum_s);
    assign rght_sat_s = sat_spd(rght_sum_s);
    assign too_fast_s = (abs17(lft_sat_s) > LIM) || (abs17(rght_sat_s) > LIM);
    assign unused_s   = ^{prod_s[7:0], st3_s[3:0], ptch_rt[5:0]};

    // Next-state logic; RUN is entered on the same edge ss_tmr reaches 255.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            OFF: begin
                if (pwr_up) state_nxt_s = RAMP;
                else        state_nxt_s = OFF;
            end
            RAMP: begin
                if (!pwr_up)                                  state_nxt_s = OFF;
                else if (tmr_wrap_s && (ss_tmr_r == 8'd254)) state_nxt_s = RUN;
                else                                          state_nxt_s = RAMP;
            end
            RUN: begin
                if (!pwr_up)        state_nxt_s = OFF;
                else if (rider_off) state_nxt_s = RAMP;
                else                state_nxt_s = RUN;
            end
            default: state_nxt_s = OFF;
        endcase
    end

    // State register and soft-start timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= OFF;
            presc_r   <= {PRESC_W{1'b0}};
            ss_tmr_r  <= 8'd0;
            ss_done_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ss_done_r <= (state_nxt_s == RUN);
            if ((state_nxt_s == OFF) || rider_off) begin
                presc_r  <= {PRESC_W{1'b0}};
                ss_tmr_r <= 8'd0;
            end else if (state_r == RAMP) begin
                presc_r <= presc_r + PRESC_W'(1);
                if (tmr_wrap_s) ss_tmr_r <= ss_tmr_r + 8'd1;
            end
        end
    end

    // Saturating integrator, held at zero whenever the platform is unpowered or unoccupied.
    always_ff @(posedge clk) begin
        if (rst || !pwr_up || (state_r == OFF) || rider_off) begin
            integ_r <= 18'sd0;
        end else if (acc_s) begin
            integ_r <= sat18(integ_sum_s);
        end
    end

    // Pipeline registers; losing pwr_up drops every in-flight sample.
    always_ff @(posedge clk) begin
        if (rst || !pwr_up) begin
            v_s1_r     <= 1'b0;
            err_s1_r   <= 10'sd0;
            i_s1_r     <= 12'sd0;
            rt_s1_r    <= 10'sd0;
            v_s2_r     <= 1'b0;
            pid_s2_r   <= 12'sd0;
            out_vld_r  <= 1'b0;
            lft_spd_r  <= {SPD_W{1'b0}};
            rght_spd_r <= {SPD_W{1'b0}};
            too_fast_r <= 1'b0;
        end else begin
            v_s1_r <= acc_s;
            if (acc_s) begin
                err_s1_r <= err_s;
                i_s1_r   <= integ_r[17:6];
                rt_s1_r  <= $signed(ptch_rt[15:6]);
            end
            v_s2_r <= v_s1_r;
            if (v_s1_r) pid_s2_r <= pid_s;
            out_vld_r <= v_s2_r;
            if (v_s2_r) begin
                lft_spd_r  <= lft_sat_s;
                rght_spd_r <= rght_sat_s;
                too_fast_r <= too_fast_s;
            end
        end
    end

    assign lft_spd  = lft_spd_r;
    assign rght_spd = rght_spd_r;
    assign too_fast = too_fast_r;
    assign ss_done  = ss_done_r;
    // The output stage is still in flight during the cycle pwr_up drops, so its pulse is withheld.
    assign out_vld  = out_vld_r && pwr_up;
endmodule

// File: tb/tb_balance_cntrl_p.sv
`timescale 1ns/1ps
// Directed testbench for balance_cntrl_p (FAST_SIM=1, SPD_W=12, TOO_FAST_LIM=1536).
module tb_balance_cntrl_p;
    logic clk = 1'b0;
    logic rst, vld, pwr_up, rider_off, en_steer;
    logic [15:0] ptch, ptch_rt;
    logic [11:0] steer_pot;
    logic signed [11:0] lft_spd, rght_spd;
    logic too_fast, out_vld, ss_done;
    int n_checks = 0;
    int n_fail = 0;

    balance_cntrl_p #(.FAST_SIM(1), .SPD_W(12), .TOO_FAST_LIM(1536)) dut (
        .clk(clk), .rst(rst), .vld(vld), .ptch(ptch), .ptch_rt(ptch_rt),
        .pwr_up(pwr_up), .rider_off(rider_off), .steer_pot(steer_pot), .en_steer(en_steer),
        .lft_spd(lft_spd), .rght_spd(rght_spd), .too_fast(too_fast),
        .out_vld(out_vld), .ss_done(ss_done)
    );

    always #5 clk = ~clk;

    // One vld pulse, then count edges until out_vld (gives up at 10).
    task automatic send_and_wait(input logic [15:0] p, input logic [15:0] r, output int lat);
        ptch = p; ptch_rt = r; vld = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0;
        lat = 1;
        while (out_vld !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; vld = 1'b0; pwr_up = 1'b0; rider_off = 1'b0; en_steer = 1'b0;
        ptch = 16'h0000; ptch_rt = 16'h0000; steer_pot = 12'h7FF;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        n_checks++; if (lft_spd !== 12'sd0) begin n_fail++; $display("FAIL reset_lft got=%0d exp=0", lft_spd); end
        n_checks++; if (rght_spd !== 12'sd0) begin n_fail++; $display("FAIL reset_rght got=%0d exp=0", rght_spd); end
        n_checks++; if (too_fast !== 1'b0) begin n_fail++; $display("FAIL reset_too_fast got=%b exp=0", too_fast); end
        n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld got=%b exp=0", out_vld); end
        n_checks++; if (ss_done !== 1'b0) begin n_fail++; $display("FAIL reset_ss_done got=%b exp=0", ss_done); end
    endtask

    // Power up (with a vld in the still-OFF cycle that must be ignored) and time the ramp.
    task automatic test_ramp(input int id);
        int seen;
        pwr_up = 1'b1; vld = 1'b1; ptch = 16'h7FFF;
        @(posedge clk); #1;
        vld = 1'b0; ptch = 16'h0000;
        seen = 0;
        for (int i = 1; i < 32640; i++) begin
            @(posedge clk); #1;
            if (out_vld !== 1'b0) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL ramp%0d_off_vld_ignored out_vld_count=%0d exp=0", id, seen); end
        n_checks++; if (ss_done !== 1'b0) begin n_fail++; $display("FAIL ramp%0d_early got=%b exp=0", id, ss_done); end
        @(posedge clk); #1;
        n_checks++; if (ss_done !== 1'b1) begin n_fail++; $display("FAIL ramp%0d_done got=%b exp=1", id, ss_done); end
    endtask

    task automatic test_nominal(input int id);
        int lat;
        en_steer = 1'b0;
        send_and_wait(16'h0010, 16'h0000, lat);
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL nominal%0d_latency got=%0d exp=3", id, lat); end
        n_checks++; if (lft_spd !== 12'sd79) begin n_fail++; $display("FAIL nominal%0d_lft got=%0d exp=79", id, lft_spd); end
        n_checks++; if (rght_spd !== 12'sd79) begin n_fail++; $display("FAIL nominal%0d_rght got=%0d exp=79", id, rght_spd); end
        n_checks++; if (too_fast !== 1'b0) begin n_fail++; $display("FAIL nominal%0d_too_fast got=%b exp=0", id, too_fast); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL nominal%0d_pulse got=%b exp=0", id, out_vld); end
        n_checks++; if (lft_spd !== 12'sd79) begin n_fail++; $display("FAIL nominal%0d_hold got=%0d exp=79", id, lft_spd); end
    endtask

    task automatic test_steering();
        int lat;
        en_steer = 1'b1; steer_pot = 12'hFFF;
        send_and_wait(16'h0000, 16'h0000, lat);
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL steer_hi_latency got=%0d exp=3", lat); end
        n_checks++; if (lft_spd !== 12'sd288) begin n_fail++; $display("FAIL steer_hi_lft got=%0d exp=288", lft_spd); end
        n_checks++; if (rght_spd !== -12'sd288) begin n_fail++; $display("FAIL steer_hi_rght got=%0d exp=-288", rght_spd); end
        steer_pot = 12'h000;
        send_and_wait(16'h0000, 16'h0000, lat);
        n_checks++; if (lft_spd !== -12'sd288) begin n_fail++; $display("FAIL steer_lo_lft got=%0d exp=-288", lft_spd); end
        n_checks++; if (rght_spd !== 12'sd288) begin n_fail++; $display("FAIL steer_lo_rght got=%0d exp=288", rght_spd); end
        n_checks++; if (too_fast !== 1'b0) begin n_fail++; $display("FAIL steer_lo_too_fast got=%b exp=0", too_fast); end
        en_steer = 1'b0; steer_pot = 12'h7FF;
    endtask

    task automatic test_saturation();
        int lat;
        send_and_wait(16'h7FFF, 16'h0000, lat);
        n_checks++; if (lft_spd !== 12'sd2039) begin n_fail++; $display("FAIL sat_pos_lft got=%0d exp=2039", lft_spd); end
        n_checks++; if (rght_spd !== 12'sd2039) begin n_fail++; $display("FAIL sat_pos_rght got=%0d exp=2039", rght_spd); end
        n_checks++; if (too_fast !== 1'b1) begin n_fail++; $display("FAIL sat_pos_too_fast got=%b exp=1", too_fast); end
    endtask

    // Integrator is 527 here; I, D, negative P, then negative saturation.
    task automatic test_pid_terms();
        int lat;
        send_and_wait(16'h0000, 16'h0000, lat);
        n_checks++; if (lft_spd !== 12'sd7) begin n_fail++; $display("FAIL i_term got=%0d exp=7", lft_spd); end
        send_and_wait(16'h0000, 16'h0100, lat);
        n_checks++; if (lft_spd !== 12'sd3) begin n_fail++; $display("FAIL d_term got=%0d exp=3", lft_spd); end
        send_and_wait(16'hFF9C, 16'h0000, lat);
        n_checks++; if (rght_spd !== -12'sd491) begin n_fail++; $display("FAIL neg_pitch got=%0d exp=-491", rght_spd); end
        send_and_wait(16'h8000, 16'h0000, lat);
        n_checks++; if (lft_spd !== -12'sd2040) begin n_fail++; $display("FAIL sat_neg_lft got=%0d exp=-2040", lft_spd); end
        n_checks++; if (too_fast !== 1'b1) begin n_fail++; $display("FAIL sat_neg_too_fast got=%b exp=1", too_fast); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rt_v [3];
        logic signed [11:0] exp_v [3];
        rt_v = '{16'h0400, 16'hFC00, 16'h0000};
        exp_v = '{-12'sd18, 12'sd13, -12'sd2};
        ptch = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            ptch_rt = rt_v[i]; vld = 1'b1;
            @(posedge clk); #1;
        end
        vld = 1'b0; ptch_rt = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (out_vld !== 1'b1 || lft_spd !== exp_v[i])
                begin n_fail++; $display("FAIL b2b_%0d got vld=%b lft=%0d exp vld=1 lft=%0d", i, out_vld, lft_spd, exp_v[i]); end
            @(posedge clk); #1;
        end
        n_checks++; if (out_vld !== 1'b0 || lft_spd !== -12'sd2)
            begin n_fail++; $display("FAIL b2b_hold got vld=%b lft=%0d exp vld=0 lft=-2", out_vld, lft_spd); end
    endtask

    task automatic test_abort();
        int seen;
        seen = 0; ptch = 16'h0010; ptch_rt = 16'h0000;
        for (int c = 0; c < 10; c++) begin
            vld = (c < 3); pwr_up = (c < 3);
            #1;
            if (out_vld !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        vld = 1'b0;
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL abort_out_vld count=%0d exp=0", seen); end
        n_checks++; if (lft_spd !== 12'sd0) begin n_fail++; $display("FAIL abort_lft got=%0d exp=0", lft_spd); end
        n_checks++; if (rght_spd !== 12'sd0) begin n_fail++; $display("FAIL abort_rght got=%0d exp=0", rght_spd); end
        n_checks++; if (too_fast !== 1'b0 || ss_done !== 1'b0)
            begin n_fail++; $display("FAIL abort_flags got too_fast=%b ss_done=%b exp 0 0", too_fast, ss_done); end
    endtask

    // Integrator is 16 here; rider_off sends RUN back to an empty ramp.
    task automatic test_rider_off();
        int lat;
        rider_off = 1'b1;
        @(posedge clk); #1;
        rider_off = 1'b0;
        n_checks++; if (ss_done !== 1'b0) begin n_fail++; $display("FAIL rider_off_ss_done got=%b exp=0", ss_done); end
        send_and_wait(16'h7FFF, 16'h0000, lat);
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL rider_off_latency got=%0d exp=3", lat); end
        n_checks++; if (lft_spd !== 12'sd0 || too_fast !== 1'b0)
            begin n_fail++; $display("FAIL rider_off_tmr_zero got lft=%0d too_fast=%b exp 0 0", lft_spd, too_fast); end
        repeat (300) @(posedge clk);
        #1;
        send_and_wait(16'h7FFF, 16'h0000, lat);
        n_checks++; if (lft_spd !== 12'sd15 || rght_spd !== 12'sd15)
            begin n_fail++; $display("FAIL ramp_scale got lft=%0d rght=%0d exp 15 15", lft_spd, rght_spd); end
    endtask

    task automatic test_reset_midpipe();
        int seen;
        seen = 0;
        ptch = 16'h7FFF; vld = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (lft_spd !== 12'sd0 || rght_spd !== 12'sd0 || ss_done !== 1'b0)
            begin n_fail++; $display("FAIL midpipe_rst got lft=%0d rght=%0d ss_done=%b exp 0 0 0", lft_spd, rght_spd, ss_done); end
        for (int i = 0; i < 5; i++) begin
            if (out_vld !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL midpipe_out_vld count=%0d exp=0", seen); end
    endtask

    initial begin
        test_reset();
        test_ramp(1);
        test_nominal(1);
        test_steering();
        test_saturation();
        test_pid_terms();
        test_back_to_back();
        test_abort();
        test_ramp(2);
        test_nominal(2);
        test_rider_off();
        test_reset_midpipe();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
